// File: rtl/bta_operand_loader.sv
// ----------------------------------------------------------------------------
// bta_operand_loader
//
// Upstream feeder for the 8-operand binary-tree CLA adder. Operands arrive one
// per cycle on a valid/ready stream and are buffered into eight parallel slots
// (op_a..op_h). Once a group closes (8th beat or in_last), the slots are held
// stable for the tree latency, then the tree sum is captured into a result
// register presented on its own valid/ready handshake.
//
// Parameters:
//   M    - operand width
//   LAT  - tree adder latency in clock edges
//   SUMW - width of tree sum / res_sum (M+3 holds 8*(2^M-1) exactly)
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - operand stream handshake
//   in_data, in_last     - operand value, marks final operand of short group
//   op_a..op_h           - parallel operands to the tree adder
//   op_c0                - tree carry-in, tied 0
//   tree_sum             - sum returned by the tree adder
//   res_valid/res_ready  - result handshake
//   res_sum, res_count   - captured sum, number of real operands (1..8)
//   res_err              - (BTA_LOADER_SELFCHECK_EN only) 1 = tree_sum differed
//                          from the internally accumulated reference sum
//
// Optional feature macro: BTA_LOADER_SELFCHECK_EN
// ----------------------------------------------------------------------------
module bta_operand_loader #(
    parameter int M    = 16,
    parameter int LAT  = 3,
    parameter int SUMW = M + 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [M-1:0]    in_data,
    input  logic            in_last,
    output logic [M-1:0]    op_a,
    output logic [M-1:0]    op_b,
    output logic [M-1:0]    op_c,
    output logic [M-1:0]    op_d,
    output logic [M-1:0]    op_e,
    output logic [M-1:0]    op_f,
    output logic [M-1:0]    op_g,
    output logic [M-1:0]    op_h,
    output logic            op_c0,
    input  logic [SUMW-1:0] tree_sum,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [SUMW-1:0] res_sum,
    output logic [3:0]      res_count
`ifdef BTA_LOADER_SELFCHECK_EN
    ,
    output logic            res_err
`endif
);

    localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         idx_q;
    logic [M-1:0]       ops_q [8];
    logic [CW-1:0]      cnt_q;
    logic               res_valid_q;
    logic [SUMW-1:0]    res_sum_q;
    logic [3:0]         res_count_q;
`ifdef BTA_LOADER_SELFCHECK_EN
    logic [SUMW-1:0]    ref_q;
    logic               res_err_q;
`endif

    logic accept;
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_count_q <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                ops_q[i] <= '0;
            end
`ifdef BTA_LOADER_SELFCHECK_EN
            ref_q       <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        ops_q[idx_q] <= in_data;
                        idx_q        <= idx_q + 3'd1;
`ifdef BTA_LOADER_SELFCHECK_EN
                        ref_q        <= ref_q + SUMW'(in_data);
`endif
                        if (idx_q == 3'd7 || in_last) begin
                            // Slots beyond the last written one must read 0
                            // so the tree sums only the real operands.
                            for (int unsigned i = 0; i < 8; i++) begin
                                if (i > 32'(idx_q)) begin
                                    ops_q[i[2:0]] <= '0;
                                end
                            end
                            res_count_q <= {1'b0, idx_q} + 4'd1;
                            cnt_q       <= CW'(LAT);
                            state_q     <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    // Capture on the LAT+1-th edge after the operands settled.
                    if (cnt_q == '0) begin
                        res_sum_q   <= tree_sum;
                        res_valid_q <= 1'b1;
`ifdef BTA_LOADER_SELFCHECK_EN
                        res_err_q   <= (ref_q != tree_sum);
`endif
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end

                DONE: begin
                    if (res_valid_q && res_ready) begin
                        res_valid_q <= 1'b0;
                        idx_q       <= '0;
                        for (int unsigned i = 0; i < 8; i++) begin
                            ops_q[i] <= '0;
                        end
`ifdef BTA_LOADER_SELFCHECK_EN
                        ref_q       <= '0;
                        res_err_q   <= 1'b0;
`endif
                        state_q     <= FILL;
                    end
                end

                default: state_q <= FILL;
            endcase
        end
    end

    // Decoded from registered state only: no in_valid -> in_ready path.
    assign in_ready  = (state_q == FILL);
    assign op_a      = ops_q[0];
    assign op_b      = ops_q[1];
    assign op_c      = ops_q[2];
    assign op_d      = ops_q[3];
    assign op_e      = ops_q[4];
    assign op_f      = ops_q[5];
    assign op_g      = ops_q[6];
    assign op_h      = ops_q[7];
    assign op_c0     = 1'b0;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_count = res_count_q;
`ifdef BTA_LOADER_SELFCHECK_EN
    assign res_err   = res_err_q;
`endif

endmodule

// File: tb/tb_bta_operand_loader.sv
// ----------------------------------------------------------------------------
// tb_bta_operand_loader
//
// Directed bench for bta_operand_loader with a 3-stage pipelined tree adder
// model. Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_bta_operand_loader;

    localparam int M    = 16;
    localparam int LAT  = 3;
    localparam int SUMW = M + 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [M-1:0]    in_data;
    logic            in_last;
    logic [M-1:0]    op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
    logic            op_c0;
    logic [SUMW-1:0] tree_sum;
    logic            res_valid;
    logic            res_ready;
    logic [SUMW-1:0] res_sum;
    logic [3:0]      res_count;
`ifdef BTA_LOADER_SELFCHECK_EN
    logic            res_err;
`endif

    int checks   = 0;
    int failures = 0;

    // Tree adder model: three registered stages, optional +1 corruption.
    logic [SUMW-1:0] s1, s2, s3;
    logic            corrupt = 1'b0;

    always @(posedge clk) begin
        s1 <= SUMW'(op_a) + SUMW'(op_b) + SUMW'(op_c) + SUMW'(op_d) +
              SUMW'(op_e) + SUMW'(op_f) + SUMW'(op_g) + SUMW'(op_h) +
              SUMW'(op_c0) + SUMW'(corrupt);
        s2 <= s1;
        s3 <= s2;
    end
    assign tree_sum = s3;

    bta_operand_loader #(.M(M), .LAT(LAT), .SUMW(SUMW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .op_d      (op_d),
        .op_e      (op_e),
        .op_f      (op_f),
        .op_g      (op_g),
        .op_h      (op_h),
        .op_c0     (op_c0),
        .tree_sum  (tree_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_count (res_count)
`ifdef BTA_LOADER_SELFCHECK_EN
        ,
        .res_err   (res_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one beat from a negedge; accepted on the following posedge.
    task automatic send(input logic [M-1:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        check_val("in_ready_fill", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    // Complete the handshake with res_ready high (leaves res_ready high).
    task automatic handshake();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("res_valid_cleared", 32'(res_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        res_ready = 1'b1;

        // ---- reset state
        #12;
        check_val("rst_op_a",      32'(op_a), 32'd0);
        check_val("rst_op_h",      32'(op_h), 32'd0);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        check_val("rst_res_sum",   32'(res_sum), 32'd0);
        check_val("rst_res_count", 32'(res_count), 32'd0);
`ifdef BTA_LOADER_SELFCHECK_EN
        check_val("rst_res_err",   32'(res_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("in_ready_after_rst", 32'(in_ready), 32'd1);
        check_val("op_c0", 32'(op_c0), 32'd0);

        // ---- group 1..8, res_ready high; exact capture latency
        for (int i = 1; i <= 8; i++) send(M'(i), 1'b0);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            if (k <= LAT) begin
                check_val("t1_res_valid_early", 32'(res_valid), 32'd0);
                check_val("t1_in_ready_hold",   32'(in_ready), 32'd0);
            end
        end
        check_val("t1_res_valid", 32'(res_valid), 32'd1);
        check_val("t1_res_sum",   32'(res_sum), 32'd36);
        check_val("t1_res_count", 32'(res_count), 32'd8);
        check_val("t1_op_a",      32'(op_a), 32'd1);
        check_val("t1_op_h",      32'(op_h), 32'd8);
        @(posedge clk);
        #1;
        check_val("t1_res_valid_clr", 32'(res_valid), 32'd0);
        check_val("t1_in_ready",      32'(in_ready), 32'd1);
        check_val("t1_op_a_clr",      32'(op_a), 32'd0);

        // ---- 8 x 0xFFFF, in_last on 8th beat (same as full group)
        for (int i = 1; i <= 8; i++) send(16'hFFFF, (i == 8));
        wait_res();
        check_val("t2_res_sum",   32'(res_sum), 32'h7FFF8);
        check_val("t2_res_count", 32'(res_count), 32'd8);
        @(posedge clk);
        #1;

        // ---- short group 10,20,30 with in_last on 30
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b1);
        for (int k = 0; k < LAT; k++) begin
            check_val("t3_op_c", 32'(op_c), 32'd30);
            check_val("t3_op_dh_zero", 32'(op_d | op_e | op_f | op_g | op_h), 32'd0);
            @(posedge clk);
            #1;
        end
        wait_res();
        check_val("t3_res_sum",   32'(res_sum), 32'd60);
        check_val("t3_res_count", 32'(res_count), 32'd3);
        @(posedge clk);
        #1;

        // ---- single-beat group, downstream stalls, in_valid held with 0xAAAA
        res_ready = 1'b0;
        send(16'd5, 1'b1);
        check_val("t4_op_b_zero", 32'(op_b), 32'd0);
        wait_res();
        check_val("t4_res_count", 32'(res_count), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_val("t4_res_valid_stall", 32'(res_valid), 32'd1);
            check_val("t4_res_sum_stall",   32'(res_sum), 32'd5);
            check_val("t4_in_ready_stall",  32'(in_ready), 32'd0);
            check_val("t4_op_a_stall",      32'(op_a), 32'd5);
        end
        handshake();
        check_val("t4_in_ready_after", 32'(in_ready), 32'd1);
        check_val("t4_op_a_cleared",   32'(op_a), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("t4_first_beat_op_a", 32'(op_a), 32'hAAAA);
        send(16'd1, 1'b1);
        wait_res();
        check_val("t4b_res_sum",   32'(res_sum), 32'hAAAB);
        check_val("t4b_res_count", 32'(res_count), 32'd2);
        @(posedge clk);
        #1;

        // ---- reset on the 2nd HOLD cycle aborts the group
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        send(16'd9, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("t5_op_a",      32'(op_a), 32'd0);
        check_val("t5_op_c",      32'(op_c), 32'd0);
        check_val("t5_res_valid", 32'(res_valid), 32'd0);
        check_val("t5_res_sum",   32'(res_sum), 32'd0);
        check_val("t5_res_count", 32'(res_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("t5_in_ready", 32'(in_ready), 32'd1);
        begin
            int seen = 0;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                if (res_valid) seen++;
            end
            check_val("t5_no_result", 32'(seen), 32'd0);
        end
        send(16'd100, 1'b0);
        send(16'd200, 1'b1);
        wait_res();
        check_val("t5_recover_sum",   32'(res_sum), 32'd300);
        check_val("t5_recover_count", 32'(res_count), 32'd2);
        @(posedge clk);
        #1;

`ifdef BTA_LOADER_SELFCHECK_EN
        // ---- self-check: corrupted tree then clean tree
        corrupt = 1'b1;
        for (int i = 1; i <= 8; i++) send(M'(i), 1'b0);
        wait_res();
        check_val("t6_bad_sum", 32'(res_sum), 32'd37);
        check_val("t6_bad_err", 32'(res_err), 32'd1);
        @(posedge clk);
        #1;
        corrupt = 1'b0;
        for (int i = 1; i <= 8; i++) send(M'(i), 1'b0);
        wait_res();
        check_val("t6_good_sum", 32'(res_sum), 32'd36);
        check_val("t6_good_err", 32'(res_err), 32'd0);
        @(posedge clk);
        #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
